// File: rtl/ref_mem_pkg.sv
// Shared constants, state encoding and helpers for the reference-pixel memory sequencer.
package ref_mem_pkg;

  localparam int PIXEL    = 8;
  localparam int X        = 32;
  localparam int NUM_BANK = 32;
  localparam int ADDR_W   = 7;
  localparam int ROW_W    = PIXEL * X;
  localparam int BANK_W   = $clog2(NUM_BANK);
  localparam int LOAD_W   = 13;
  localparam int RD_LEN_W = 8;

  localparam logic [LOAD_W-1:0] MAX_LOAD_ROWS = 13'd4096;

  localparam logic RD_8R = 1'b0;
  localparam logic RD_1R = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    READ = 2'd2,
    DONE = 2'd3
  } state_t;

  // Requests beyond the memory capacity (128 entries x 32 banks) are trimmed.
  function automatic logic [LOAD_W-1:0] clamp_rows(input logic [LOAD_W-1:0] rows);
    return (rows > MAX_LOAD_ROWS) ? MAX_LOAD_ROWS : rows;
  endfunction

endpackage

// File: rtl/ref_rd_seq.sv
// Read-address / row-select generator feeding the ME PE array.
// 8-row mode issues one address per cycle; single-row mode holds each
// address for 8 cycles while the row select steps 0..7.
module ref_rd_seq
  import ref_mem_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base,
  input  logic [RD_LEN_W-1:0] len,
  input  logic                mode,
  output logic [ADDR_W-1:0]   rd_address,
  output logic                rd_req,
  output logic                rd8R_en,
  output logic [3:0]          rdR_sel,
  output logic                last
);

  logic                active_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [RD_LEN_W-1:0] remain_q;
  logic [2:0]          sub_q;
  logic                mode_q;
  logic                step_addr;

  // Address advances every cycle in 8-row mode, after the 8th sub-row otherwise.
  assign step_addr = (mode_q == RD_8R) || (sub_q == 3'd7);
  assign last      = active_q && step_addr && (remain_q == 8'd1);

  // Down-counts remaining addresses; address wraps naturally at 2^ADDR_W.
  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= 1'b0;
      addr_q   <= '0;
      remain_q <= '0;
      sub_q    <= '0;
      mode_q   <= RD_8R;
    end else if (start) begin
      active_q <= (len != '0);
      addr_q   <= base;
      remain_q <= len;
      sub_q    <= '0;
      mode_q   <= mode;
    end else if (active_q) begin
      if (step_addr) begin
        sub_q    <= '0;
        addr_q   <= addr_q + 1'b1;
        remain_q <= remain_q - 1'b1;
        if (remain_q == 8'd1) begin
          active_q <= 1'b0;
        end
      end else begin
        sub_q <= sub_q + 1'b1;
      end
    end
  end

  // Outputs are forced to zero outside an active read sequence.
  always_comb begin
    rd_req     = active_q;
    rd8R_en    = active_q && (mode_q != RD_1R);
    rdR_sel    = active_q ? {1'b0, sub_q} : 4'd0;
    rd_address = active_q ? addr_q : '0;
  end

endmodule

// File: rtl/ref_mem_ctrl.sv
// Ref_mem sequencer: one start runs a load phase (rows interleaved across
// banks) followed by a read phase driving the PE array address sequence.
//
//   state | meaning
//   IDLE  | waiting for start; cfg latched on accept
//   LOAD  | in_ready high, each handshake writes one row
//   READ  | read sequencer issuing addresses
//   DONE  | one cycle; done pulse follows, then back to IDLE
module ref_mem_ctrl
  import ref_mem_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [LOAD_W-1:0]          cfg_load_rows,
  input  logic [ADDR_W-1:0]          cfg_rd_base,
  input  logic [RD_LEN_W-1:0]        cfg_rd_len,
  input  logic                       cfg_rd_mode,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ROW_W-1:0]           in_data,
  output logic [ROW_W-1:0]           ref_input,
  output logic [NUM_BANK-1:0]        Bank_sel,
  output logic [ADDR_W*NUM_BANK-1:0] write_address_all,
  output logic [ADDR_W-1:0]          rd_address,
  output logic                       rd8R_en,
  output logic [3:0]                 rdR_sel,
  output logic                       rd_req,
  output logic                       busy,
  output logic                       done
);

  state_t                state_q, state_d;
  logic                  busy_q, done_q;
  logic [LOAD_W-1:0]     load_rows_q;
  logic [ADDR_W-1:0]     rd_base_q;
  logic [RD_LEN_W-1:0]   rd_len_q;
  logic                  rd_mode_q;
  logic [LOAD_W-1:0]     row_cnt_q;
  logic [ROW_W-1:0]      ref_input_q;
  logic [NUM_BANK-1:0]   bank_sel_q;
  logic [ADDR_W-1:0]     wr_addr_q;

  logic                  start_ok;
  logic                  hs;
  logic                  last_row;
  logic                  rd_start;
  logic                  rd_last;
  logic [ADDR_W-1:0]     seq_base;
  logic [RD_LEN_W-1:0]   seq_len;
  logic                  seq_mode;

  assign start_ok = start && !busy_q && (state_q == IDLE);
  assign in_ready = (state_q == LOAD);
  assign hs       = in_valid && in_ready;
  assign last_row = hs && (row_cnt_q == load_rows_q - 13'd1);

  // A read launched straight from IDLE must use the live cfg, since the
  // latched copy only lands on the same edge.
  always_comb begin
    seq_base = rd_base_q;
    seq_len  = rd_len_q;
    seq_mode = rd_mode_q;
    if (state_q == IDLE) begin
      seq_base = cfg_rd_base;
      seq_len  = cfg_rd_len;
      seq_mode = cfg_rd_mode;
    end
  end

  // Next-state decode; rd_start kicks the read sequencer on entry to READ.
  always_comb begin
    state_d  = state_q;
    rd_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_ok) begin
          if (cfg_load_rows != '0) begin
            state_d = LOAD;
          end else if (cfg_rd_len != '0) begin
            state_d  = READ;
            rd_start = 1'b1;
          end else begin
            state_d = DONE;
          end
        end
      end
      LOAD: begin
        if (last_row) begin
          if (rd_len_q != '0) begin
            state_d  = READ;
            rd_start = 1'b1;
          end else begin
            state_d = DONE;
          end
        end
      end
      READ: begin
        if (rd_last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, job configuration, row counter and busy/done flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      load_rows_q <= '0;
      rd_base_q   <= '0;
      rd_len_q    <= '0;
      rd_mode_q   <= RD_8R;
      row_cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == DONE);
      if (start_ok) begin
        busy_q <= 1'b1;
      end else if (done_q) begin
        busy_q <= 1'b0;
      end
      if (start_ok) begin
        load_rows_q <= clamp_rows(cfg_load_rows);
        rd_base_q   <= cfg_rd_base;
        rd_len_q    <= cfg_rd_len;
        rd_mode_q   <= cfg_rd_mode;
        row_cnt_q   <= '0;
      end else if (hs) begin
        row_cnt_q <= row_cnt_q + 13'd1;
      end
    end
  end

  // Registered write port: row r lands in bank r mod 32 at entry r/32.
  always_ff @(posedge clk) begin
    if (rst) begin
      ref_input_q <= '0;
      bank_sel_q  <= '0;
      wr_addr_q   <= '0;
    end else if (hs) begin
      ref_input_q <= in_data;
      bank_sel_q  <= NUM_BANK'(1) << row_cnt_q[BANK_W-1:0];
      wr_addr_q   <= row_cnt_q[BANK_W +: ADDR_W];
    end else begin
      bank_sel_q <= '0;
    end
  end

  ref_rd_seq u_rd_seq (
    .clk        (clk),
    .rst        (rst),
    .start      (rd_start),
    .base       (seq_base),
    .len        (seq_len),
    .mode       (seq_mode),
    .rd_address (rd_address),
    .rd_req     (rd_req),
    .rd8R_en    (rd8R_en),
    .rdR_sel    (rdR_sel),
    .last       (rd_last)
  );

  assign ref_input         = ref_input_q;
  assign Bank_sel          = bank_sel_q;
  assign write_address_all = {NUM_BANK{wr_addr_q}};
  assign busy              = busy_q;
  assign done              = done_q;

endmodule

// File: tb/tb_ref_mem_ctrl.sv
// Bench for ref_mem_ctrl: a per-job timeline model predicts every output for
// every cycle after start; a negedge process compares DUT against it, and a
// few literal expectations pin specific events.
module tb_ref_mem_ctrl;
  import ref_mem_pkg::*;

  localparam int MAXT = 4300;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [12:0]  cfg_load_rows;
  logic [6:0]   cfg_rd_base;
  logic [7:0]   cfg_rd_len;
  logic         cfg_rd_mode;
  logic         in_valid;
  logic         in_ready;
  logic [255:0] in_data;
  logic [255:0] ref_input;
  logic [31:0]  Bank_sel;
  logic [223:0] write_address_all;
  logic [6:0]   rd_address;
  logic         rd8R_en;
  logic [3:0]   rdR_sel;
  logic         rd_req;
  logic         busy;
  logic         done;

  ref_mem_ctrl dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .cfg_load_rows     (cfg_load_rows),
    .cfg_rd_base       (cfg_rd_base),
    .cfg_rd_len        (cfg_rd_len),
    .cfg_rd_mode       (cfg_rd_mode),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_data           (in_data),
    .ref_input         (ref_input),
    .Bank_sel          (Bank_sel),
    .write_address_all (write_address_all),
    .rd_address        (rd_address),
    .rd8R_en           (rd8R_en),
    .rdR_sel           (rdR_sel),
    .rd_req            (rd_req),
    .busy              (busy),
    .done              (done)
  );

  always #5 clk = ~clk;

  // expected timeline, indexed by cycle offset from the start cycle
  logic         e_ready  [MAXT];
  logic [31:0]  e_bank   [MAXT];
  logic [6:0]   e_waddr  [MAXT];
  logic [255:0] e_data   [MAXT];
  logic         e_rdreq  [MAXT];
  logic [6:0]   e_rdaddr [MAXT];
  logic         e_r8     [MAXT];
  logic [3:0]   e_sel    [MAXT];
  logic         e_busy   [MAXT];
  logic         e_done   [MAXT];

  // sampled DUT values, for the literal checks
  logic         a_ready  [MAXT];
  logic [31:0]  a_bank   [MAXT];
  logic [6:0]   a_waddr  [MAXT];
  logic         a_rdreq  [MAXT];
  logic [6:0]   a_rdaddr [MAXT];
  logic         a_r8     [MAXT];
  logic [3:0]   a_sel    [MAXT];
  logic         a_busy   [MAXT];
  logic         a_done   [MAXT];

  logic [255:0] hold_data;
  logic [6:0]   hold_waddr;
  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  int cur_t  = 0;
  int job_id = 0;

  function automatic logic [255:0] data_of(input int job, input int t);
    logic [31:0] w;
    w = (32'(job) << 24) ^ 32'h005A_0000 ^ 32'(t);
    return {8{w}};
  endfunction

  function automatic bit valid_at(input int vpat, input int t);
    if (vpat == 0) return (t >= 1);
    return (t % 2) == 1;
  endfunction

  task automatic cmp(input string name, input int t, input logic [255:0] act,
                     input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s job=%0d t=%0d got %h expected %h", name, job_id, t, act, exp);
    end
  endtask

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s job=%0d got %0h expected %0h", name, job_id, act, exp);
    end
  endtask

  // Builds the whole expected trace of one job from its parameters.
  task automatic build_model(input int load_cfg, input int base, input int len,
                             input int mode, input int vpat, input int rst_at,
                             output int end_t);
    int load, n, h_last, r0, d, step, nrd;
    for (int t = 0; t < MAXT; t++) begin
      e_ready[t] = 0; e_bank[t] = 0; e_waddr[t] = 0; e_data[t] = 0;
      e_rdreq[t] = 0; e_rdaddr[t] = 0; e_r8[t] = 0; e_sel[t] = 0;
      e_busy[t] = 0; e_done[t] = 0;
    end
    load = (load_cfg > 4096) ? 4096 : load_cfg;
    n = 0;
    h_last = 0;
    if (load > 0) begin
      for (int t = 1; n < load && t < MAXT - 2; t++) begin
        e_ready[t] = 1;
        if (valid_at(vpat, t)) begin
          e_bank[t+1]  = 32'd1 << (n % 32);
          e_waddr[t+1] = 7'(n / 32);
          e_data[t+1]  = data_of(job_id, t);
          n++;
          h_last = t;
        end
      end
    end
    r0   = (load > 0) ? h_last + 1 : 1;
    step = mode ? 8 : 1;
    nrd  = len * step;
    for (int j = 0; j < nrd; j++) begin
      e_rdreq[r0+j]  = 1;
      e_rdaddr[r0+j] = 7'((base + j / step) % 128);
      e_sel[r0+j]    = 4'(mode ? j % 8 : 0);
      e_r8[r0+j]     = !mode;
    end
    d = r0 + nrd;
    for (int t = 1; t <= d + 1; t++) e_busy[t] = 1;
    e_done[d+1] = 1;
    end_t = d + 4;
    if (rst_at >= 0) begin
      for (int t = rst_at + 1; t < MAXT; t++) begin
        e_ready[t] = 0; e_bank[t] = 0; e_rdreq[t] = 0; e_r8[t] = 0;
        e_sel[t] = 0; e_busy[t] = 0; e_done[t] = 0;
      end
      end_t = rst_at + 4;
    end
    for (int t = 0; t <= end_t; t++) begin
      if (rst_at >= 0 && t > rst_at) begin
        e_data[t]  = '0;
        e_waddr[t] = '0;
      end else if (e_bank[t] == 0) begin
        e_data[t]  = (t == 0) ? hold_data  : e_data[t-1];
        e_waddr[t] = (t == 0) ? hold_waddr : e_waddr[t-1];
      end
    end
    hold_data  = e_data[end_t];
    hold_waddr = e_waddr[end_t];
  endtask

  // Per-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      int t;
      t = cur_t;
      cmp("in_ready", t, 256'(in_ready), 256'(e_ready[t]));
      cmp("Bank_sel", t, 256'(Bank_sel), 256'(e_bank[t]));
      cmp("ref_input", t, ref_input, e_data[t]);
      cmp("write_address_all", t, 256'(write_address_all), 256'({32{e_waddr[t]}}));
      cmp("rd_req", t, 256'(rd_req), 256'(e_rdreq[t]));
      cmp("rd8R_en", t, 256'(rd8R_en), 256'(e_r8[t]));
      cmp("rdR_sel", t, 256'(rdR_sel), 256'(e_sel[t]));
      cmp("busy", t, 256'(busy), 256'(e_busy[t]));
      cmp("done", t, 256'(done), 256'(e_done[t]));
      if (e_rdreq[t]) cmp("rd_address", t, 256'(rd_address), 256'(e_rdaddr[t]));
      a_ready[t] = in_ready;  a_bank[t] = Bank_sel;  a_waddr[t] = write_address_all[6:0];
      a_rdreq[t] = rd_req;    a_rdaddr[t] = rd_address; a_r8[t] = rd8R_en;
      a_sel[t] = rdR_sel;     a_busy[t] = busy;      a_done[t] = done;
    end
  end

  // Caller is #1 after a posedge; returns #1 after a posedge.
  task automatic run_job(input int load_cfg, input int base, input int len,
                         input int mode, input int vpat, input int rst_at,
                         input int ign_a, input int ign_b);
    int end_t;
    job_id++;
    build_model(load_cfg, base, len, mode, vpat, rst_at, end_t);
    for (int t = 0; t <= end_t; t++) begin
      cur_t  = t;
      chk_en = 1'b1;
      start  = (t == 0) || (t == ign_a) || (t == ign_b);
      if (t == 0) begin
        cfg_load_rows = 13'(load_cfg);
        cfg_rd_base   = 7'(base);
        cfg_rd_len    = 8'(len);
        cfg_rd_mode   = (mode != 0);
      end else begin
        cfg_load_rows = 13'd7;
        cfg_rd_base   = 7'd99;
        cfg_rd_len    = 8'd3;
        cfg_rd_mode   = (mode == 0);
      end
      in_valid = valid_at(vpat, t);
      in_data  = data_of(job_id, t);
      rst      = (rst_at >= 0) && (t == rst_at || t == rst_at + 1);
      @(posedge clk);
      #1;
    end
    chk_en   = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    rst      = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
    cfg_load_rows = '0; cfg_rd_base = '0; cfg_rd_len = '0; cfg_rd_mode = 1'b0;
    hold_data = '0; hold_waddr = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    lit("reset_busy", 32'(busy), 32'd0);
    lit("reset_in_ready", 32'(in_ready), 32'd0);
    lit("reset_Bank_sel", Bank_sel, 32'd0);
    lit("reset_rd_req", {rd_req, rd8R_en, rdR_sel, done}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // reset mid-LOAD after three rows
    run_job(10, 0, 0, 0, 0, 4, -1, -1);
    lit("rst_row2_bank", a_bank[4], 32'h4);
    lit("rst_after_bank", a_bank[5], 32'h0);
    lit("rst_after_ready", 32'(a_ready[5]), 32'd0);
    lit("rst_after_busy", 32'(a_busy[5]), 32'd0);

    // 40 rows, valid held high
    run_job(40, 0, 0, 0, 0, -1, -1, -1);
    lit("row0_bank", a_bank[2], 32'h1);
    lit("row32_bank", a_bank[34], 32'h1);
    lit("row32_addr", 32'(a_waddr[34]), 32'd1);
    lit("row39_bank", a_bank[41], 32'h80);
    lit("row39_addr", 32'(a_waddr[41]), 32'd1);
    lit("load40_done", 32'(a_done[42]), 32'd1);

    // 4 rows with toggling valid, then two 8-row reads
    run_job(4, 3, 2, 0, 1, -1, -1, -1);
    lit("toggle_gap", a_bank[7], 32'h0);
    lit("toggle_row3_bank", a_bank[8], 32'h8);
    lit("toggle_ready_drop", 32'(a_ready[8]), 32'd0);
    lit("toggle_rd_first", 32'(a_rdaddr[8]), 32'd3);

    // 8-row read with address wrap
    run_job(0, 126, 4, 0, 0, -1, -1, -1);
    lit("wrap_a0", 32'(a_rdaddr[1]), 32'd126);
    lit("wrap_a1", 32'(a_rdaddr[2]), 32'd127);
    lit("wrap_a2", 32'(a_rdaddr[3]), 32'd0);
    lit("wrap_a3", 32'(a_rdaddr[4]), 32'd1);
    lit("wrap_end_req", 32'(a_rdreq[5]), 32'd0);
    lit("wrap_done", 32'(a_done[6]), 32'd1);

    // single-row read, two addresses
    run_job(0, 5, 2, 1, 0, -1, -1, -1);
    lit("r1_sel7_addr", 32'(a_rdaddr[8]), 32'd5);
    lit("r1_sel7", 32'(a_sel[8]), 32'd7);
    lit("r1_next_addr", 32'(a_rdaddr[9]), 32'd6);
    lit("r1_next_sel", 32'(a_sel[9]), 32'd0);
    lit("r1_r8_low", 32'(a_r8[12]), 32'd0);
    lit("r1_end_req", 32'(a_rdreq[17]), 32'd0);

    // empty job, extra starts while busy and in the done cycle
    run_job(0, 0, 0, 0, 0, -1, 1, 2);
    lit("empty_done", 32'(a_done[2]), 32'd1);
    lit("empty_busy_clear", 32'(a_busy[3]), 32'd0);

    // load count above capacity is clamped to 4096 rows
    run_job(5000, 127, 1, 1, 0, -1, -1, -1);
    lit("clamp_last_bank", a_bank[4097], 32'h8000_0000);
    lit("clamp_last_addr", 32'(a_waddr[4097]), 32'd127);
    lit("clamp_rd_addr", 32'(a_rdaddr[4097]), 32'd127);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
